// File: rtl/route_test_pkg.sv
// Shared types and polynomial constants for the route-test PRBS link (generator and checker).
package route_test_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSeed   = 2'd1,
    StCheck  = 2'd2,
    StLocked = 2'd3
  } route_chk_state_t;

  localparam int unsigned PRBS7_W    = 7;
  localparam int unsigned PRBS7_TAP  = 6;
  localparam int unsigned PRBS15_W   = 15;
  localparam int unsigned PRBS15_TAP = 14;

endpackage

// File: rtl/route_prbs_checker_if.sv
// Sample/control/status bundle between a route-test PRBS checker and its driver or readout.
interface route_prbs_checker_if #(
    parameter int unsigned ERR_W = 16
) ();

    logic             en;
    logic             rx_valid;
    logic             rx_bit;
    logic             clear;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic             err_sat;
    logic [1:0]       state_o;

    modport master (
        output en, rx_valid, rx_bit, clear,
        input  locked, err_pulse, err_count, err_sat, state_o
    );

    modport slave (
        input  en, rx_valid, rx_bit, clear,
        output locked, err_pulse, err_count, err_sat, state_o
    );

endinterface

// File: rtl/route_prbs_lfsr.sv
// One step of a two-tap Fibonacci LFSR: shift in either an external bit or the feedback bit.
module route_prbs_lfsr
    import route_test_pkg::*;
#(
    parameter int unsigned LFSR_W = PRBS7_W,
    parameter int unsigned TAP_LO = PRBS7_TAP
) (
    input  logic [LFSR_W-1:0] state,
    input  logic              load,
    input  logic              load_bit,
    output logic              exp_bit,
    output logic [LFSR_W-1:0] next
);

    always_comb begin
        exp_bit = state[LFSR_W-1] ^ state[TAP_LO-1];
        next    = {state[LFSR_W-2:0], load ? load_bit : exp_bit};
    end

endmodule

// File: rtl/route_prbs_checker.sv
// Self-synchronising PRBS receiver: seeds from the wire, confirms lock, then flywheels and
// counts bit errors on the routed arc.
module route_prbs_checker
    import route_test_pkg::*;
#(
    parameter int unsigned LFSR_W      = PRBS7_W,
    parameter int unsigned TAP_LO      = PRBS7_TAP,
    parameter int unsigned LOCK_COUNT  = 16,
    parameter int unsigned LOSS_THRESH = 4,
    parameter int unsigned ERR_W       = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    route_prbs_checker_if.slave bus
);

    localparam int unsigned      SeedW     = $clog2(LFSR_W + 1);
    localparam logic [SeedW-1:0] SeedLast  = SeedW'(LFSR_W - 1);
    localparam logic [7:0]       MatchLast = 8'(LOCK_COUNT - 1);
    localparam logic [3:0]       MissLast  = 4'(LOSS_THRESH - 1);

    route_chk_state_t  state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_next;
    logic [SeedW-1:0]  seed_cnt_q, seed_cnt_d;
    logic [7:0]        match_cnt_q, match_cnt_d;
    logic [3:0]        miss_cnt_q, miss_cnt_d;
    logic [ERR_W-1:0]  err_count_q, err_count_d;
    logic              err_sat_q, err_sat_d;
    logic              err_pulse_q, err_pulse_d;
    logic              exp_bit;
    logic              load;

    assign load = (state_q == StSeed);

    route_prbs_lfsr #(
        .LFSR_W(LFSR_W),
        .TAP_LO(TAP_LO)
    ) u_lfsr (
        .state   (lfsr_q),
        .load    (load),
        .load_bit(bus.rx_bit),
        .exp_bit (exp_bit),
        .next    (lfsr_next)
    );

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        seed_cnt_d  = seed_cnt_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_count_d = err_count_q;
        err_pulse_d = 1'b0;

        if (!bus.en) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d    = StSeed;
                    seed_cnt_d = '0;
                end
                StSeed: begin
                    if (bus.rx_valid) begin
                        lfsr_d = lfsr_next;
                        if (seed_cnt_q == SeedLast) begin
                            seed_cnt_d = '0;
                            // A stuck-at-0 wire leaves the seed all-zero; keep reseeding.
                            if (lfsr_next != '0) begin
                                state_d     = StCheck;
                                match_cnt_d = '0;
                            end
                        end else begin
                            seed_cnt_d = seed_cnt_q + 1'b1;
                        end
                    end
                end
                StCheck: begin
                    if (bus.rx_valid) begin
                        lfsr_d = lfsr_next;
                        if (bus.rx_bit == exp_bit) begin
                            match_cnt_d = match_cnt_q + 8'd1;
                            if (match_cnt_q == MatchLast) begin
                                state_d    = StLocked;
                                miss_cnt_d = '0;
                            end
                        end else begin
                            state_d     = StSeed;
                            seed_cnt_d  = '0;
                            match_cnt_d = '0;
                        end
                    end
                end
                StLocked: begin
                    if (bus.rx_valid) begin
                        // Flywheel: the LFSR runs on its own prediction, never on rx_bit.
                        lfsr_d = lfsr_next;
                        if (bus.rx_bit != exp_bit) begin
                            err_pulse_d = 1'b1;
                            miss_cnt_d  = miss_cnt_q + 4'd1;
                            if (err_count_q != '1) begin
                                err_count_d = err_count_q + 1'b1;
                            end
                            if (miss_cnt_q == MissLast) begin
                                state_d    = StSeed;
                                seed_cnt_d = '0;
                            end
                        end else begin
                            miss_cnt_d = '0;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (bus.clear) begin
            err_count_d = '0;
        end
        err_sat_d = (err_count_d == '1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            lfsr_q      <= '0;
            seed_cnt_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            err_count_q <= '0;
            err_sat_q   <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            seed_cnt_q  <= seed_cnt_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_count_q <= err_count_d;
            err_sat_q   <= err_sat_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign bus.locked    = (state_q == StLocked);
    assign bus.state_o   = state_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_count = err_count_q;
    assign bus.err_sat   = err_sat_q;

endmodule
